// File: rtl/bnn_window_conv.sv
// Binary convolution over 5-tap windows: sign-binarize, XNOR with per-filter weights,
// popcount, threshold, and gather one NUM_FILT x NUM_WIN feature map per frame.
module bnn_window_conv #(
    parameter int DW       = 16,
    parameter int TAPS     = 5,
    parameter int NUM_WIN  = 6,
    parameter int NUM_FILT = 4,
    parameter int CW       = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       win_valid,
    input  logic [TAPS*DW-1:0]         win_data,
    output logic                       win_ready,
    input  logic                       frame_clr,
    input  logic [NUM_FILT*TAPS-1:0]   weights,
    input  logic [NUM_FILT*CW-1:0]     thresh,
    output logic [NUM_FILT*NUM_WIN-1:0] feat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 win_idx
);

    localparam int FW = NUM_FILT * NUM_WIN;
    localparam logic [2:0] LAST_IDX = 3'(NUM_WIN - 1);

    logic [FW-1:0]       acc_r;
    logic [FW-1:0]       feat_r;
    logic                out_valid_r;
    logic [2:0]          win_idx_r;

    logic [TAPS-1:0]     tap_bit_s;
    logic [NUM_FILT-1:0] col_bit_s;
    logic [FW-1:0]       merged_s;
    logic [FW-1:0]       acc_next_s;
    logic [FW-1:0]       feat_next_s;
    logic                out_valid_next_s;
    logic [2:0]          win_idx_next_s;
    logic                win_ready_s;
    logic                accept_s;
    logic                last_s;
    logic                unused_mag_s;

    function automatic logic [CW-1:0] popcount(input logic [TAPS-1:0] v);
        logic [CW-1:0] sum;
        sum = {CW{1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + {{(CW-1){1'b0}}, v[k]};
        end
        return sum;
    endfunction

    // Only the sign bit of each sample reaches the datapath.
    assign unused_mag_s = ^win_data;

    // Binarize taps and produce one feature bit per filter for the presented window.
    always_comb begin
        logic [TAPS-1:0] match_v;
        logic [CW-1:0]   pop_v;
        tap_bit_s = {TAPS{1'b0}};
        col_bit_s = {NUM_FILT{1'b0}};
        match_v   = {TAPS{1'b0}};
        pop_v     = {CW{1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            tap_bit_s[k] = ~win_data[k*DW+DW-1];
        end
        for (int f = 0; f < NUM_FILT; f++) begin
            match_v      = ~(tap_bit_s ^ weights[f*TAPS +: TAPS]);
            pop_v        = popcount(match_v);
            col_bit_s[f] = (pop_v >= thresh[f*CW +: CW]);
        end
    end

    // Handshake qualifiers; only the frame-completing window can stall.
    always_comb begin
        last_s      = (win_idx_r == LAST_IDX);
        win_ready_s = !(last_s && out_valid_r && !out_ready);
        accept_s    = win_valid && win_ready_s;
    end

    // Accumulator with the current column inserted at win_idx.
    always_comb begin
        merged_s = acc_r;
        for (int f = 0; f < NUM_FILT; f++) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                merged_s[f*NUM_WIN+w] = (win_idx_r == 3'(w)) ? col_bit_s[f]
                                                              : acc_r[f*NUM_WIN+w];
            end
        end
    end

    // Next-state: frame_clr beats accept; a completing accept reloads feat without a bubble.
    always_comb begin
        acc_next_s       = acc_r;
        feat_next_s      = feat_r;
        win_idx_next_s   = win_idx_r;
        out_valid_next_s = out_valid_r;
        if (out_valid_r && out_ready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
        if (frame_clr) begin
            acc_next_s     = {FW{1'b0}};
            win_idx_next_s = 3'd0;
        end else if (accept_s) begin
            if (last_s) begin
                feat_next_s      = merged_s;
                out_valid_next_s = 1'b1;
                acc_next_s       = {FW{1'b0}};
                win_idx_next_s   = 3'd0;
            end else begin
                acc_next_s     = merged_s;
                win_idx_next_s = win_idx_r + 3'd1;
            end
        end else begin
            acc_next_s     = acc_r;
            win_idx_next_s = win_idx_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {FW{1'b0}};
            feat_r      <= {FW{1'b0}};
            out_valid_r <= 1'b0;
            win_idx_r   <= 3'd0;
        end else begin
            acc_r       <= acc_next_s;
            feat_r      <= feat_next_s;
            out_valid_r <= out_valid_next_s;
            win_idx_r   <= win_idx_next_s;
        end
    end

    assign win_ready = win_ready_s;
    assign feat      = feat_r;
    assign out_valid = out_valid_r;
    assign win_idx   = win_idx_r;

endmodule

// File: tb/tb_bnn_window_conv.sv
// Directed and randomized bench for bnn_window_conv against a frame-level reference model.
module tb_bnn_window_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        win_valid;
    logic [79:0] win_data;
    logic        win_ready;
    logic        frame_clr;
    logic [19:0] weights;
    logic [11:0] thresh;
    logic [23:0] feat;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  win_idx;

    int n_pass  = 0;
    int n_total = 0;

    bit          m_map [4][6];
    int          m_idx;
    logic [23:0] m_feat;
    bit          m_ov;
    logic [23:0] feat_a;

    bnn_window_conv dut (
        .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_data(win_data),
        .win_ready(win_ready), .frame_clr(frame_clr), .weights(weights),
        .thresh(thresh), .feat(feat), .out_valid(out_valid),
        .out_ready(out_ready), .win_idx(win_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feature bit from arithmetic: count taps whose sign agrees with the weight.
    function automatic bit ref_bit(input logic [79:0] d, input logic [4:0] w, input logic [2:0] th);
        int p = 0;
        for (int k = 0; k < 5; k++) begin
            int s = $signed(d[k*16 +: 16]);
            bit pos = (s >= 0);
            if (pos == w[k]) p++;
        end
        return (p >= int'(th));
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 4; f++)
            for (int w = 0; w < 6; w++) m_map[f][w] = 1'b0;
        m_idx  = 0;
        m_feat = 24'h0;
        m_ov   = 1'b0;
    endtask

    task automatic cycle();
        bit ready, acc_now;
        bit col [4];
        @(negedge clk);
        ready   = !(m_idx == 5 && m_ov && !out_ready);
        acc_now = win_valid && ready;
        for (int f = 0; f < 4; f++) col[f] = ref_bit(win_data, weights[f*5 +: 5], thresh[f*3 +: 3]);
        chk("win_ready", 32'(win_ready), 32'(ready));
        @(posedge clk);
        #1;
        if (m_ov && out_ready) m_ov = 1'b0;
        if (frame_clr) begin
            for (int f = 0; f < 4; f++)
                for (int w = 0; w < 6; w++) m_map[f][w] = 1'b0;
            m_idx = 0;
        end else if (acc_now) begin
            for (int f = 0; f < 4; f++) m_map[f][m_idx] = col[f];
            if (m_idx == 5) begin
                for (int f = 0; f < 4; f++)
                    for (int w = 0; w < 6; w++) begin
                        m_feat[f*6+w] = m_map[f][w];
                        m_map[f][w]   = 1'b0;
                    end
                m_ov  = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("feat", 32'(feat), 32'(m_feat));
        chk("win_idx", 32'(win_idx), 32'(m_idx));
    endtask

    task automatic send(input logic [79:0] d);
        win_valid = 1'b1;
        win_data  = d;
        cycle();
        win_valid = 1'b0;
    endtask

    function automatic logic [79:0] rand_win();
        logic [79:0] d;
        for (int k = 0; k < 5; k++) d[k*16 +: 16] = 16'($urandom);
        return d;
    endfunction

    initial begin
        logic [79:0] pos_w, neg_w, mix_w;
        pos_w = {5{16'h0001}};
        neg_w = {5{16'h8000}};
        mix_w = {16'h0010, 16'hFFF0, 16'h0010, 16'hFFF0, 16'h0010};
        rst_n = 1'b0; win_valid = 1'b0; win_data = 80'h0; frame_clr = 1'b0;
        weights = 20'hFFFFF; thresh = 12'h6DB; out_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_feat", 32'(feat), 32'h0);
        chk("rst_win_idx", 32'(win_idx), 32'h0);
        rst_n = 1'b1;
        cycle();
        chk("rst_win_ready", 32'(win_ready), 32'h1);

        // All positive, weights +1, thresh 3.
        for (int i = 0; i < 6; i++) send(pos_w);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_feat", 32'(feat), 32'hFFFFFF);
        cycle();
        chk("t1_pulse", 32'(out_valid), 32'h0);

        // All negative: weights +1 gives 0, weights -1 gives all ones.
        thresh = 12'h249;
        for (int i = 0; i < 6; i++) send(neg_w);
        chk("t2_feat_w1", 32'(feat), 32'h000000);
        weights = 20'h00000;
        for (int i = 0; i < 6; i++) send(neg_w);
        chk("t2_feat_w0", 32'(feat), 32'hFFFFFF);

        // Mixed signs; filter 0 matches fully, filter 1 not at all, 2-3 unreachable.
        weights = {5'b00000, 5'b00000, 5'b01010, 5'b10101};
        thresh  = {3'd7, 3'd7, 3'd1, 3'd5};
        for (int i = 0; i < 6; i++) send(mix_w);
        chk("t3_feat", 32'(feat), 32'h00003F);

        // Alternating window signs.
        weights = 20'hFFFFF; thresh = 12'h6DB;
        for (int i = 0; i < 6; i++) send((i % 2 == 0) ? pos_w : neg_w);
        chk("t4_feat", 32'(feat), 32'h555555);

        // Backpressure: frame A waits while B's first five windows accumulate.
        out_ready = 1'b0;
        weights = 20'($urandom); thresh = 12'($urandom);
        for (int i = 0; i < 6; i++) send(rand_win());
        feat_a = m_feat;
        win_data = rand_win();
        for (int i = 0; i < 5; i++) send(rand_win());
        win_valid = 1'b1;
        win_data  = rand_win();
        cycle();
        cycle();
        chk("bp_stall_ready", 32'(win_ready), 32'h0);
        chk("bp_hold_feat", 32'(feat), 32'(feat_a));
        chk("bp_hold_idx", 32'(win_idx), 32'h5);
        out_ready = 1'b1;
        cycle();
        win_valid = 1'b0;
        chk("bp_no_bubble", 32'(out_valid), 32'h1);
        cycle();

        // frame_clr after three windows drops them and the simultaneous one.
        weights = 20'hFFFFF; thresh = 12'h6DB;
        for (int i = 0; i < 3; i++) send(neg_w);
        frame_clr = 1'b1;
        send(neg_w);
        frame_clr = 1'b0;
        chk("clr_idx", 32'(win_idx), 32'h0);
        for (int i = 0; i < 6; i++) send(pos_w);
        chk("clr_feat", 32'(feat), 32'hFFFFFF);
        cycle();
        chk("clr_one_frame", 32'(out_valid), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            win_valid = ($urandom_range(3) != 0);
            win_data  = rand_win();
            out_ready = ($urandom_range(2) != 0);
            frame_clr = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) begin
                weights = 20'($urandom);
                thresh  = 12'($urandom);
            end
            cycle();
        end
        win_valid = 1'b0; frame_clr = 1'b0; out_ready = 1'b1;
        cycle();

        // Asynchronous reset mid-frame with a frame pending.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(rand_win());
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_out_valid", 32'(out_valid), 32'h0);
        chk("amid_feat", 32'(feat), 32'h0);
        chk("amid_win_idx", 32'(win_idx), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bnn_window_conv.md
Name: bnn_window_conv

Overview:
- Downstream neighbour of the 1x5 window fetch stage in the BNN-VAD datapath.
- Consumes 5-tap windows of 16-bit signed samples, six windows per 20-sample frame (stride 3).
- For each of NUM_FILT binary filters: binarizes each window, XNORs it with the filter weights, popcounts, then thresholds to a single feature bit.
- Gathers one NUM_FILT x NUM_WIN binary feature map per frame and hands it to the next BNN layer over a valid/ready handshake.

Parameters:
- DW, 16, sample width (two's complement)
- TAPS, 5, samples per window
- NUM_WIN, 6, windows per frame
- NUM_FILT, 4, number of binary filters
- CW, 3, popcount/threshold width; must hold TAPS

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- win_valid  in  1  window present on win_data
- win_data  in  TAPS*DW  tap k at [k*DW +: DW]; tap 0 is the earliest sample
- win_ready  out  1  stage accepts a window this cycle
- frame_clr  in  1  synchronous discard of any partial frame
- weights  in  NUM_FILT*TAPS  bit [f*TAPS+k]: 1 = +1, 0 = -1; static during a frame
- thresh  in  NUM_FILT*CW  per-filter popcount threshold at [f*CW +: CW]
- feat  out  NUM_FILT*NUM_WIN  feature bit (filter f, window w) at [f*NUM_WIN+w]
- out_valid  out  1  feat holds a complete frame
- out_ready  in  1  consumer takes feat
- win_idx  out  3  index of the next window to be accepted (0..NUM_WIN-1); debug

Behaviour:
- Reset (async, rst_n=0):
  - feat=0, out_valid=0, win_idx=0, accumulator=0.
  - win_ready=1 once reset is released.
- Accept: a window is accepted on a rising edge when win_valid && win_ready.
- Binarize: tap bit b_k = ~win_data[k*DW+DW-1], so value >=0 gives 1 and value <0 gives 0.
- Match: m_{f,k} = ~(b_k ^ weights[f*TAPS+k]).
- Popcount: p_f = sum over k of m_{f,k}, range 0..TAPS, unsigned CW bits.
- Feature bit: bit_f = (p_f >= thresh_f). Comparison is unsigned, so thresh 0 gives 1 and thresh > TAPS gives 0.
- The bit is computed combinationally from the accepted window and written to acc[f*NUM_WIN+win_idx] on the accepting edge.
- Window counter: win_idx increments on each accept. Accepting at win_idx = NUM_WIN-1 completes the frame:
  - feat <= acc with the final column merged in.
  - out_valid <= 1.
  - acc <= 0 and win_idx <= 0.
- Latency: out_valid rises in the cycle after the 6th accept.
- Output handshake:
  - feat and out_valid hold while out_valid && !out_ready.
  - On out_valid && out_ready, out_valid clears next cycle unless a new frame completes on the same edge. In that case out_valid stays 1 and feat takes the new frame, with no bubble.
- Backpressure: win_ready = !(win_idx==NUM_WIN-1 && out_valid && !out_ready).
  - Windows 0..4 of the next frame accumulate while an older frame waits.
  - Only the completing window stalls.
- frame_clr:
  - Clears acc and win_idx next edge.
  - Takes priority over a simultaneous accept; that window is dropped.
  - Does not touch feat or out_valid.
- win_valid while win_ready=0: nothing is accepted and no state changes. The upstream stage must hold the window.
- Reset mid-frame: all partial state is lost and output returns to reset values immediately.
- weights and thresh are sampled only on accepting edges. Changing them between windows is legal but mixes filters within a frame.

Test Plan:
- All 30 windows' taps = 16'h0001, weights all 1, thresh all 3; 6 accepts in consecutive cycles, out_ready=1 -> out_valid pulses 1 cycle after 6th accept, feat = 24'hFFFFFF.
- Taps 16'h8000, weights all 1, thresh 1 -> feat = 24'h000000. Same taps with weights all 0 -> feat = 24'hFFFFFF.
- Taps {0x0010, 0xFFF0, 0x0010, 0xFFF0, 0x0010} (tap0 first); filter0 weights 5'b10101 (p=5), filter1 5'b01010 (p=0); thresh filter0 5, filter1 1; filters 2-3 thresh 7 -> feat[5:0] = 6'h3F, feat[11:6] = 0, feat[23:12] = 0.
- Alternate window sign per window (w even positive), weights all 1, thresh 3 -> each filter row = 6'b010101, feat = 24'h555555.
- out_ready=0 after frame A; stream frame B continuously -> windows 0..4 accepted, win_ready=0 at win_idx=5, feat stays A. Raise out_ready -> B's 6th window accepted on that edge, out_valid stays 1, feat=B.
- Assert frame_clr after 3 windows, then feed 6 windows -> exactly one frame produced containing only the post-clear windows. Assert rst_n=0 mid-frame -> out_valid=0, feat=0, win_idx=0 asynchronously.
